agc_dsp_array: RTL and testbench

// - NSAMP-lane AGC core: each lane computes out = sat((dat + offset) * scale), with scale/offset shared by all lanes.
// - Scale/offset are double-buffered: staged, then applied to all lanes in one cycle on a frame-sync boundary via a req/ack FSM.
// - Keeps per-window saturation statistics for the AGC servo loop. Sits between the ADC sample deserialiser and the trigger beamformer.

---
 rtl/agc_dsp_array.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_agc_dsp_array.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_dsp_array.sv
// -----------------------------------------------------------------------------
// agc_dsp_array
//
// NSAMP-lane automatic-gain-control core placed between the ADC sample
// deserialiser and the trigger beamformer. Every lane computes
//    out = sat((dat + offset) * scale)
// with one scale/offset pair shared by all lanes. Scale and offset are
// double-buffered: software writes a staging copy at any time, and a req/ack
// handshake copies both staging registers into the active registers on the next
// frame-sync boundary, so all lanes switch gain in the same cycle.
// Per-window saturation counts feed the AGC servo loop.
//
// Optional feature macro: AGC_DSP_ROUND_EN
//    defined   : y = (prod + 2^(LSB-1)) >>> LSB  (round half up)
//    undefined : y = prod >>> LSB                (floor)
//    Pipeline latency is identical in both builds.
//
// Ports
//    clk_i          clock
//    rst_i          synchronous reset, active high
//    en_i           0 forces the product (and so every output) to zero
//    dat_i          NSAMP signed samples, lane k at [k*DAT_BITS +: DAT_BITS]
//    scale_i        staged scale (unsigned, Q_SCALE fractional bits)
//    ce_scale_i     load scale_i into staging
//    offset_i       staged offset (signed, Q_OFFSET fractional bits)
//    ce_offset_i    load offset_i into staging
//    apply_req_i    request a staging -> active transfer
//    sync_i         frame boundary strobe
//    apply_busy_o   transfer FSM not idle
//    apply_ack_o    one-cycle pulse after the transfer
//    out_o          NSAMP saturated signed outputs, 4 clocks after dat_i
//    abs_o          per-lane magnitude (one's-complement style)
//    gt_o / lt_o    per-lane high / low saturation flags
//    gt_count_o     high-saturation count over the last window
//    lt_count_o     low-saturation count over the last window
//    count_valid_o  one-cycle pulse when the counts update
// -----------------------------------------------------------------------------
module agc_dsp_array #(
   parameter int NSAMP         = 8,
   parameter int DAT_BITS      = 12,
   parameter int Q_DAT         = 0,
   parameter int OFFSET_BITS   = 16,
   parameter int Q_OFFSET      = 8,
   parameter int Q_SCALE       = 12,
   parameter int SCALE_IN      = 5,
   parameter int NFRAC_OUT     = 2,
   parameter int NBITS         = 5,
   parameter int WINDOW_CYCLES = 1024,
   parameter int COUNT_BITS    = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic [NSAMP*DAT_BITS-1:0]    dat_i,
   input  logic [16:0]                  scale_i,
   input  logic                         ce_scale_i,
   input  logic [OFFSET_BITS-1:0]       offset_i,
   input  logic                         ce_offset_i,
   input  logic                         apply_req_i,
   input  logic                         sync_i,
   output logic                         apply_busy_o,
   output logic                         apply_ack_o,
   output logic [NSAMP*NBITS-1:0]       out_o,
   output logic [NSAMP*(NBITS-1)-1:0]   abs_o,
   output logic [NSAMP-1:0]             gt_o,
   output logic [NSAMP-1:0]             lt_o,
   output logic [COUNT_BITS-1:0]        gt_count_o,
   output logic [COUNT_BITS-1:0]        lt_count_o,
   output logic                         count_valid_o
);

   localparam int Q_SUM      = (Q_DAT > Q_OFFSET) ? Q_DAT : Q_OFFSET;
   localparam int SH_DAT     = Q_SUM - Q_DAT;
   localparam int SH_OFF     = Q_SUM - Q_OFFSET;
   localparam int SUM_BITS   = 27;
   localparam int SCALE_BITS = 17;
   // one extra bit so the round-half-up addend can never overflow
   localparam int PROD_BITS  = SUM_BITS + SCALE_BITS + 1;
   localparam int LSB        = Q_SUM + Q_SCALE + SCALE_IN - NFRAC_OUT;
   localparam int WIN_BITS   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int POP_BITS   = $clog2(NSAMP + 1);

   localparam logic [SCALE_BITS-1:0]       SCALE_ONE = SCALE_BITS'(1) << Q_SCALE;
   localparam logic signed [PROD_BITS-1:0] Y_MAX = (PROD_BITS'(1) <<< (NBITS - 1)) - PROD_BITS'(1);
   localparam logic signed [PROD_BITS-1:0] Y_MIN = -(PROD_BITS'(1) <<< (NBITS - 1));

   // ---------------------------------------------------------------- apply FSM
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_APPLY, ST_ACK} state_t;

   state_t                          state_q, state_d;
   logic [SCALE_BITS-1:0]           scale_stage_q, scale_stage_d;
   logic [SCALE_BITS-1:0]           scale_act_q, scale_act_d;
   logic [OFFSET_BITS-1:0]          offset_stage_q, offset_stage_d;
   logic signed [OFFSET_BITS-1:0]   offset_act_q, offset_act_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         // a sync arriving together with the request is not an apply point
         ST_IDLE:  if (apply_req_i) state_d = ST_ARMED;
         ST_ARMED: if (sync_i)      state_d = ST_APPLY;
         ST_APPLY: state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      scale_stage_d  = ce_scale_i  ? scale_i  : scale_stage_q;
      offset_stage_d = ce_offset_i ? offset_i : offset_stage_q;
      scale_act_d    = scale_act_q;
      offset_act_d   = offset_act_q;
      // the registered staging value is copied, so a write landing in the
      // APPLY cycle waits for the next transfer
      if (state_q == ST_APPLY) begin
         scale_act_d  = scale_stage_q;
         offset_act_d = offset_stage_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         scale_stage_q  <= SCALE_ONE;
         scale_act_q    <= SCALE_ONE;
         offset_stage_q <= '0;
         offset_act_q   <= '0;
      end else begin
         state_q        <= state_d;
         scale_stage_q  <= scale_stage_d;
         scale_act_q    <= scale_act_d;
         offset_stage_q <= offset_stage_d;
         offset_act_q   <= offset_act_d;
      end
   end

   assign apply_busy_o = (state_q != ST_IDLE);
   assign apply_ack_o  = (state_q == ST_ACK);

   // ------------------------------------------------------- shared stage 1
   // The scale is carried alongside the sum so a sample always sees the
   // scale/offset pair that was active when it entered the pipeline.
   logic [SCALE_BITS-1:0] scale_s1_q, scale_s1_d;
   logic                  en_s1_q, en_s1_d;

   always_comb begin
      scale_s1_d = scale_act_q;
      en_s1_d    = en_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scale_s1_q <= '0;
         en_s1_q    <= 1'b0;
      end else begin
         scale_s1_q <= scale_s1_d;
         en_s1_q    <= en_s1_d;
      end
   end

   // ------------------------------------------------------------ lane datapath
   for (genvar gi = 0; gi < NSAMP; gi++) begin : g_lane
      logic signed [DAT_BITS-1:0]   dat_lane;
      logic signed [SUM_BITS-1:0]   sum_q, sum_d;
      logic signed [PROD_BITS-1:0]  prod_q, prod_d;
      logic signed [PROD_BITS-1:0]  y;
      logic [NBITS-1:0]             sat_q, sat_d;
      logic                         gt_s3_q, gt_s3_d, lt_s3_q, lt_s3_d;
      logic [NBITS-1:0]             out_q, out_d;
      logic [NBITS-2:0]             abs_q, abs_d;
      logic                         gt_q, gt_d, lt_q, lt_d;

      assign dat_lane = dat_i[gi*DAT_BITS +: DAT_BITS];

      // stage 1: align binary points and add the offset
      always_comb begin
         sum_d = (SUM_BITS'(dat_lane) <<< SH_DAT) + (SUM_BITS'(offset_act_q) <<< SH_OFF);
      end

      // stage 2: multiply by the unsigned scale
      always_comb begin
         prod_d = '0;
         if (en_s1_q) begin
            prod_d = PROD_BITS'(sum_q) * PROD_BITS'($signed({1'b0, scale_s1_q}));
         end
      end

      // stage 3: requantise and saturate
      always_comb begin
`ifdef AGC_DSP_ROUND_EN
         y = (prod_q + (PROD_BITS'(1) <<< (LSB - 1))) >>> LSB;
`else
         y = prod_q >>> LSB;
`endif
         sat_d   = y[NBITS-1:0];
         gt_s3_d = 1'b0;
         lt_s3_d = 1'b0;
         if (y > Y_MAX) begin
            sat_d   = Y_MAX[NBITS-1:0];
            gt_s3_d = 1'b1;
         end else if (y < Y_MIN) begin
            sat_d   = Y_MIN[NBITS-1:0];
            lt_s3_d = 1'b1;
         end
      end

      // stage 4: output register; magnitude folds -v to v-1 so it fits NBITS-1
      always_comb begin
         out_d = sat_q;
         abs_d = sat_q[NBITS-1] ? ~sat_q[NBITS-2:0] : sat_q[NBITS-2:0];
         gt_d  = gt_s3_q;
         lt_d  = lt_s3_q;
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            sum_q   <= '0;
            prod_q  <= '0;
            sat_q   <= '0;
            gt_s3_q <= 1'b0;
            lt_s3_q <= 1'b0;
            out_q   <= '0;
            abs_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
         end else begin
            sum_q   <= sum_d;
            prod_q  <= prod_d;
            sat_q   <= sat_d;
            gt_s3_q <= gt_s3_d;
            lt_s3_q <= lt_s3_d;
            out_q   <= out_d;
            abs_q   <= abs_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
         end
      end

      assign out_o[gi*NBITS +: NBITS]         = out_q;
      assign abs_o[gi*(NBITS-1) +: NBITS-1]   = abs_q;
      assign gt_o[gi]                         = gt_q;
      assign lt_o[gi]                         = lt_q;
   end

   // ------------------------------------------------------ window statistics
   logic [WIN_BITS-1:0]    win_q, win_d;
   logic [COUNT_BITS-1:0]  gt_acc_q, gt_acc_d, lt_acc_q, lt_acc_d;
   logic [COUNT_BITS-1:0]  gt_count_q, gt_count_d, lt_count_q, lt_count_d;
   logic                   count_valid_q, count_valid_d;
   logic [POP_BITS-1:0]    gt_pop, lt_pop;
   logic [COUNT_BITS:0]    gt_sum, lt_sum;
   logic [COUNT_BITS-1:0]  gt_sat, lt_sat;

   always_comb begin
      gt_pop = '0;
      lt_pop = '0;
      for (int i = 0; i < NSAMP; i++) begin
         gt_pop = gt_pop + POP_BITS'(gt_o[i]);
         lt_pop = lt_pop + POP_BITS'(lt_o[i]);
      end
      // one carry bit detects overflow; the accumulator sticks at all-ones
      gt_sum = {1'b0, gt_acc_q} + (COUNT_BITS+1)'(gt_pop);
      lt_sum = {1'b0, lt_acc_q} + (COUNT_BITS+1)'(lt_pop);
      gt_sat = gt_sum[COUNT_BITS] ? '1 : gt_sum[COUNT_BITS-1:0];
      lt_sat = lt_sum[COUNT_BITS] ? '1 : lt_sum[COUNT_BITS-1:0];

      win_d         = win_q + 1'b1;
      gt_acc_d      = gt_sat;
      lt_acc_d      = lt_sat;
      gt_count_d    = gt_count_q;
      lt_count_d    = lt_count_q;
      count_valid_d = 1'b0;
      if (win_q == WIN_BITS'(WINDOW_CYCLES - 1)) begin
         win_d         = '0;
         gt_count_d    = gt_sat;
         lt_count_d    = lt_sat;
         count_valid_d = 1'b1;
         gt_acc_d      = '0;
         lt_acc_d      = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_q         <= '0;
         gt_acc_q      <= '0;
         lt_acc_q      <= '0;
         gt_count_q    <= '0;
         lt_count_q    <= '0;
         count_valid_q <= 1'b0;
      end else begin
         win_q         <= win_d;
         gt_acc_q      <= gt_acc_d;
         lt_acc_q      <= lt_acc_d;
         gt_count_q    <= gt_count_d;
         lt_count_q    <= lt_count_d;
         count_valid_q <= count_valid_d;
      end
   end

   assign gt_count_o    = gt_count_q;
   assign lt_count_o    = lt_count_q;
   assign count_valid_o = count_valid_q;

endmodule

// File: tb/tb_agc_dsp_array.sv
// -----------------------------------------------------------------------------
// tb_agc_dsp_array
//
// Self-checking bench for agc_dsp_array at default parameters. Every sample
// driven is turned into an expected lane result by a plain-integer model of
// out = sat((dat + offset) * scale) and compared four clocks later. The bench
// keeps its own copy of the active scale/offset and switches it for samples
// driven from the second cycle after the sync that completes an apply.
// -----------------------------------------------------------------------------
module tb_agc_dsp_array;

   localparam int NSAMP      = 8;
   localparam int DAT_BITS   = 12;
   localparam int NBITS      = 5;
   localparam int COUNT_BITS = 16;

   logic                         clk = 1'b0;
   logic                         rst_i = 1'b1;
   logic                         en_i = 1'b0;
   logic [NSAMP*DAT_BITS-1:0]    dat_i = '0;
   logic [16:0]                  scale_i = '0;
   logic                         ce_scale_i = 1'b0;
   logic [15:0]                  offset_i = '0;
   logic                         ce_offset_i = 1'b0;
   logic                         apply_req_i = 1'b0;
   logic                         sync_i = 1'b0;
   logic                         apply_busy_o;
   logic                         apply_ack_o;
   logic [NSAMP*NBITS-1:0]       out_o;
   logic [NSAMP*(NBITS-1)-1:0]   abs_o;
   logic [NSAMP-1:0]             gt_o;
   logic [NSAMP-1:0]             lt_o;
   logic [COUNT_BITS-1:0]        gt_count_o;
   logic [COUNT_BITS-1:0]        lt_count_o;
   logic                         count_valid_o;

   always #5 clk = ~clk;

   agc_dsp_array dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .dat_i         (dat_i),
      .scale_i       (scale_i),
      .ce_scale_i    (ce_scale_i),
      .offset_i      (offset_i),
      .ce_offset_i   (ce_offset_i),
      .apply_req_i   (apply_req_i),
      .sync_i        (sync_i),
      .apply_busy_o  (apply_busy_o),
      .apply_ack_o   (apply_ack_o),
      .out_o         (out_o),
      .abs_o         (abs_o),
      .gt_o          (gt_o),
      .lt_o          (lt_o),
      .gt_count_o    (gt_count_o),
      .lt_count_o    (lt_count_o),
      .count_valid_o (count_valid_o)
   );

   typedef struct {
      logic [39:0] out;
      logic [31:0] abs;
      logic [7:0]  gt;
      logic [7:0]  lt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   act_scale = 4096;
   int   act_offset = 0;
   int   ack_cnt = 0;
   int   valid_cnt = 0;
   int   last_gt_cnt = 0;
   int   last_lt_cnt = 0;
   int   step_no = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", tag, step_no, got, exp);
      end
   endtask

   // Reference: integer arithmetic straight from the lane equation.
   function automatic exp_t model(input logic [95:0] dat, input int scale,
                                  input int offset, input bit en);
      exp_t   e;
      longint d, s, p, y;
      int     o;
      e.out = '0; e.abs = '0; e.gt = '0; e.lt = '0;
      for (int k = 0; k < NSAMP; k++) begin
         d = longint'($signed(dat[k*DAT_BITS +: DAT_BITS]));
         s = d * 256 + longint'(offset);
         p = en ? s * longint'(scale) : 64'sd0;
`ifdef AGC_DSP_ROUND_EN
         y = (p + (longint'(1) << 22)) >>> 23;
`else
         y = p >>> 23;
`endif
         if (y > 15) begin
            o = 15;
            e.gt[k] = 1'b1;
         end else if (y < -16) begin
            o = -16;
            e.lt[k] = 1'b1;
         end else begin
            o = int'(y);
         end
         e.out[k*NBITS +: NBITS] = o[4:0];
         e.abs[k*(NBITS-1) +: NBITS-1] = (o < 0) ? 4'(-o - 1) : 4'(o);
      end
      return e;
   endfunction

   function automatic logic [95:0] rep(input int v);
      logic [95:0] r;
      for (int k = 0; k < NSAMP; k++) r[k*DAT_BITS +: DAT_BITS] = v[11:0];
      return r;
   endfunction

   function automatic logic [95:0] rand_dat();
      logic [95:0] r;
      int          v;
      for (int k = 0; k < NSAMP; k++) begin
         if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 255) - 128;
         else                           v = $urandom_range(0, 4095) - 2048;
         r[k*DAT_BITS +: DAT_BITS] = v[11:0];
      end
      return r;
   endfunction

   // Drive one sample (control inputs are set by the caller), advance one
   // clock and compare the sample that was driven four clocks earlier.
   task automatic step(input logic [95:0] dat, input bit en);
      exp_t e;
      dat_i = dat;
      en_i  = en;
      exp_q.push_back(model(dat, act_scale, act_offset, en));
      @(posedge clk);
      #1;
      step_no++;
      if (apply_ack_o) ack_cnt++;
      if (count_valid_o) begin
         valid_cnt++;
         last_gt_cnt = gt_count_o;
         last_lt_cnt = lt_count_o;
      end
      if (exp_q.size() == 4) begin
         e = exp_q.pop_front();
         check("out", out_o, e.out);
         check("abs", abs_o, e.abs);
         check("gt",  gt_o,  e.gt);
         check("lt",  lt_o,  e.lt);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      apply_req_i = 1'b0; sync_i = 1'b0; ce_scale_i = 1'b0; ce_offset_i = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (apply_ack_o) ack_cnt++;
      end
      check("rst_out",   out_o, 0);
      check("rst_abs",   abs_o, 0);
      check("rst_gt",    gt_o, 0);
      check("rst_lt",    lt_o, 0);
      check("rst_busy",  apply_busy_o, 0);
      check("rst_ack",   apply_ack_o, 0);
      check("rst_gtcnt", gt_count_o, 0);
      check("rst_ltcnt", lt_count_o, 0);
      check("rst_valid", count_valid_o, 0);
      exp_q.delete();
      act_scale  = 4096;
      act_offset = 0;
      rst_i = 1'b0;
   endtask

   task automatic do_apply(input int scale, input int offset);
      int acks0;
      acks0 = ack_cnt;
      scale_i = scale[16:0]; offset_i = offset[15:0];
      ce_scale_i = 1'b1; ce_offset_i = 1'b1;
      step(rand_dat(), 1'b1);
      ce_scale_i = 1'b0; ce_offset_i = 1'b0;
      apply_req_i = 1'b1;
      step(rand_dat(), 1'b1);
      apply_req_i = 1'b0;
      repeat ($urandom_range(0, 3)) step(rand_dat(), $urandom_range(0, 9) != 0);
      sync_i = 1'b1;
      step(rand_dat(), 1'b1);
      sync_i = 1'b0;
      step(rand_dat(), 1'b1);
      act_scale  = scale;
      act_offset = offset;
      step(rand_dat(), 1'b1);
      check("rand_apply_ack", ack_cnt - acks0, 1);
   endtask

   // Two windows of constant input; the second window is entirely saturated.
   task automatic run_window(input int v, input int exp_gt, input int exp_lt);
      repeat (5) step(rep(v), 1'b1);
      valid_cnt = 0;
      for (int i = 0; i < 1100 && valid_cnt == 0; i++) step(rep(v), 1'b1);
      for (int i = 0; i < 1100 && valid_cnt == 1; i++) step(rep(v), 1'b1);
      check("win_pulses", valid_cnt, 2);
      check("win_gt_count", last_gt_cnt, exp_gt);
      check("win_lt_count", last_lt_cnt, exp_lt);
   endtask

   initial begin : main
      int vals[9];
      int acks0;
      int s, o;
      vals = '{8, 32, 100, 128, -200, 4, -4, 0, -1};

      do_reset();

      // basic transfer at reset defaults, including saturation and rounding corners
      foreach (vals[i]) repeat (2) step(rep(vals[i]), 1'b1);
      repeat (2) step(rep(128), 1'b0);
      repeat (4) step(rep(0), 1'b1);

      // apply: scale 2.0 staged, sync five clocks after the request
      ack_cnt = 0;
      scale_i = 17'd8192; ce_scale_i = 1'b1;
      step(rep(32), 1'b1);
      ce_scale_i = 1'b0;
      apply_req_i = 1'b1;
      step(rep(32), 1'b1);
      apply_req_i = 1'b0;
      check("busy_armed", apply_busy_o, 1);
      step(rep(32), 1'b1);
      step(rep(32), 1'b1);
      apply_req_i = 1'b1;                 // ignored: already armed
      step(rep(32), 1'b1);
      apply_req_i = 1'b0;
      step(rep(32), 1'b1);
      sync_i = 1'b1;
      step(rep(32), 1'b1);
      sync_i = 1'b0;
      scale_i = 17'd2048; ce_scale_i = 1'b1;   // lands in the APPLY cycle
      step(rep(32), 1'b1);
      ce_scale_i = 1'b0;
      act_scale = 8192;
      check("ack_pulse", apply_ack_o, 1);
      repeat (6) step(rep(32), 1'b1);
      check("ack_once", ack_cnt, 1);
      check("busy_idle", apply_busy_o, 0);

      // the write made during APPLY takes effect on the next apply
      apply_req_i = 1'b1;
      step(rep(32), 1'b1);
      apply_req_i = 1'b0;
      sync_i = 1'b1;
      step(rep(32), 1'b1);
      sync_i = 1'b0;
      step(rep(32), 1'b1);
      act_scale = 2048;
      repeat (6) step(rep(32), 1'b1);
      check("ack_second", ack_cnt, 2);

      // offset 8.0 at scale 1.0; req and sync together must not apply
      scale_i = 17'd4096; offset_i = 16'h0800;
      ce_scale_i = 1'b1; ce_offset_i = 1'b1;
      step(rep(0), 1'b1);
      ce_scale_i = 1'b0; ce_offset_i = 1'b0;
      apply_req_i = 1'b1; sync_i = 1'b1;
      step(rep(0), 1'b1);
      apply_req_i = 1'b0; sync_i = 1'b0;
      repeat (6) step(rep(0), 1'b1);
      check("same_cycle_busy", apply_busy_o, 1);
      check("same_cycle_noack", ack_cnt, 2);
      sync_i = 1'b1;
      step(rep(0), 1'b1);
      sync_i = 1'b0;
      step(rep(0), 1'b1);
      act_scale = 4096; act_offset = 2048;
      repeat (6) step(rep(0), 1'b1);
      check("ack_third", ack_cnt, 3);

      // reset while armed: abort with no acknowledge
      acks0 = ack_cnt;
      apply_req_i = 1'b1;
      step(rep(16), 1'b1);
      apply_req_i = 1'b0;
      step(rep(16), 1'b1);
      do_reset();
      sync_i = 1'b1;
      step(rep(16), 1'b1);
      sync_i = 1'b0;
      repeat (6) step(rep(16), 1'b1);
      check("rst_armed_busy", apply_busy_o, 0);
      check("rst_armed_noack", ack_cnt - acks0, 0);

      // randomized gains, offsets, samples and enables
      for (int r = 0; r < 4; r++) begin
         s = $urandom_range(512, 20000);
         o = $urandom_range(0, 65535);
         o = int'($signed(o[15:0]));
         do_apply(s, o);
         repeat (150) step(rand_dat(), $urandom_range(0, 9) != 0);
      end

      // saturation statistics at scale 1.0
      do_apply(4096, 0);
      run_window(128, 8192, 0);
      run_window(-200, 0, 8192);

      repeat (4) step(rep(0), 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
